// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency multiplier plus a restoring divider with a
// final sign-correction cycle. Results are held in hi/lo until the next completion.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    generate
        if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("mdu: WIDTH must be an even value in 8..64");
        end
        if (MUL_LATENCY < 1 || MUL_LATENCY > 4) begin : g_bad_latency
            $error("mdu: MUL_LATENCY must be in 1..4");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             uns_q, uns_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             done_q, done_d;

    // Operand conditioning for division: magnitudes and result signs.
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign a_neg  = !op[0] && a[WIDTH-1];
    assign b_neg  = !op[0] && b[WIDTH-1];
    assign b_zero = (b == '0);
    assign mag_a  = a_neg ? -a : a;
    assign mag_b  = b_neg ? -b : b;

    // Multiplier: with single-cycle latency the product comes straight from the inputs.
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_sgn;
    logic [2*WIDTH-1:0] mul_ext_a, mul_ext_b, prod;

    generate
        if (MUL_LATENCY == 1) begin : g_mul_direct
            assign mul_a   = a;
            assign mul_b   = b;
            assign mul_sgn = !op[0];
        end else begin : g_mul_reg
            assign mul_a   = opa_q;
            assign mul_b   = opb_q;
            assign mul_sgn = !uns_q;
        end
    endgenerate

    assign mul_ext_a = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
    assign mul_ext_b = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
    assign prod      = mul_ext_a * mul_ext_b;

    // One restoring-division step: opa_q shifts the dividend out and the quotient in.
    logic [WIDTH:0]   trial, diff;
    logic             fits;
    logic [WIDTH-1:0] rem_step, quo_step;

    assign trial    = {rem_q, opa_q[WIDTH-1]};
    assign diff     = trial - {1'b0, opb_q};
    assign fits     = !diff[WIDTH];
    assign rem_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step = {opa_q[WIDTH-2:0], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!op[1]) begin
                        state_d = (MUL_LATENCY == 1) ? S_IDLE : S_MUL;
                    end else if (!b_zero) begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (annul) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        dbg_state = state_q;
    end

    // The last quotient bit resolves in FIX together with sign correction, so the
    // divider spends WIDTH-1 cycles in DIV and completes WIDTH+1 cycles after accept.
    always_comb begin
        cnt_d  = cnt_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        rem_d  = rem_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        uns_d  = uns_q;
        negq_d = negq_q;
        negr_d = negr_q;
        done_d = 1'b0;
        if (!annul) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!op[1]) begin
                            if (MUL_LATENCY == 1) begin
                                hi_d   = prod[2*WIDTH-1:WIDTH];
                                lo_d   = prod[WIDTH-1:0];
                                done_d = 1'b1;
                            end else begin
                                opa_d = a;
                                opb_d = b;
                                uns_d = op[0];
                                cnt_d = CW'(MUL_LATENCY - 2);
                            end
                        end else if (b_zero) begin
                            hi_d   = a;
                            lo_d   = '1;
                            done_d = 1'b1;
                        end else begin
                            opa_d  = mag_a;
                            opb_d  = mag_b;
                            rem_d  = '0;
                            negq_d = a_neg ^ b_neg;
                            negr_d = a_neg;
                            cnt_d  = CW'(WIDTH - 2);
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        hi_d   = prod[2*WIDTH-1:WIDTH];
                        lo_d   = prod[WIDTH-1:0];
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DIV: begin
                    rem_d = rem_step;
                    opa_d = quo_step;
                    cnt_d = cnt_q - CW'(1);
                end
                default: begin
                    lo_d   = negq_q ? -quo_step : quo_step;
                    hi_d   = negr_q ? -rem_step : rem_step;
                    done_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            rem_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            uns_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            rem_q  <= rem_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            uns_q  <= uns_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu (WIDTH=32, MUL_LATENCY=2): arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_mdu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    mdu #(.WIDTH(32), .MUL_LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .annul     (annul),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model: results from plain arithmetic, timing from operation latency
    function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output int lat, output logic [31:0] rh, output logic [31:0] rl);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy, p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        lat = 2;
        rh = '0;
        rl = '0;
        case (o)
            2'd0: begin
                p  = sx * sy;
                rh = p[63:32];
                rl = p[31:0];
            end
            2'd1: begin
                p  = ux * uy;
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    lat = 1;
                    rh  = x;
                    rl  = 32'hFFFF_FFFF;
                end else begin
                    lat = 33;
                    if (o == 2'd2) begin
                        q = sx / sy;
                        r = sx % sy;
                    end else begin
                        q = longint'(ux / uy);
                        r = longint'(ux % uy);
                    end
                    rh = r[31:0];
                    rl = q[31:0];
                end
            end
        endcase
    endfunction

    int          edge_cnt = 0;
    bit          m_pend, m_done, m_busy;
    int          m_done_edge;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 1'b0;
            m_done = 1'b0;
            m_busy = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            bit          busy_before;
            int          lat;
            logic [31:0] rh, rl;
            edge_cnt++;
            busy_before = m_pend;
            m_done = 1'b0;
            if (annul) begin
                m_pend = 1'b0;
            end else begin
                if (m_pend && edge_cnt == m_done_edge) begin
                    m_hi   = m_phi;
                    m_lo   = m_plo;
                    m_done = 1'b1;
                    m_pend = 1'b0;
                end
                if (start && !busy_before) begin
                    model_op(op, a, b, lat, rh, rl);
                    if (lat == 1) begin
                        m_hi   = rh;
                        m_lo   = rl;
                        m_done = 1'b1;
                    end else begin
                        m_pend      = 1'b1;
                        m_done_edge = edge_cnt + lat - 1;
                        m_phi       = rh;
                        m_plo       = rl;
                    end
                end
            end
            m_busy = m_pend;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle done", done, m_done);
            chk("cycle busy", busy, m_busy);
            chk("cycle hi", hi, m_hi);
            chk("cycle lo", lo, m_lo);
            chk("cycle idle state", dbg_state == 2'd0, !m_busy);
        end
    end

    // driver: issue one operation, wait for done, check latency and literal results
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_lat, input logic [31:0] eh,
                          input logic [31:0] el, input bit imm, input int exp_busy,
                          output int done_edge);
        int acc;
        int bcyc;
        bit seen;
        if (!imm) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        acc   = edge_cnt;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
        seen  = 1'b0;
        bcyc  = 0;
        done_edge = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) bcyc++;
        end
        chk({name, " done seen"}, seen, 1'b1);
        if (seen) begin
            done_edge = edge_cnt;
            chk({name, " latency"}, edge_cnt - acc + 1, exp_lat);
            chk({name, " hi"}, hi, eh);
            chk({name, " lo"}, lo, el);
            if (exp_busy >= 0) chk({name, " busy cycles"}, bcyc, exp_busy);
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int d1, d2, dn;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = '0;
        b     = '0;
        annul = 1'b0;
        #3;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op("divu 100/7", 2'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 32, d1);
        run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32, d1);
        run_op("div min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, -1, d1);
        run_op("div 7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0, -1, d1);
        run_op("mult -1*2", 2'd0, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1, d1);
        run_op("multu ffffffff*2", 2'd1, 32'hFFFF_FFFF, 32'd2, 2, 32'd1, 32'hFFFF_FFFE, 1'b0, 1, d1);
        run_op("mult min*min", 2'd0, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'd0, 1'b0, -1, d1);
        run_op("divu ffffffff/1", 2'd3, 32'hFFFF_FFFF, 32'd1, 33, 32'd0, 32'hFFFF_FFFF, 1'b0, -1, d1);
        run_op("divu 5/0", 2'd3, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b0, 0, d1);

        // start issued in the done cycle
        run_op("b2b divu 100/7", 2'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 32, d1);
        run_op("b2b multu 3*4", 2'd1, 32'd3, 32'd4, 2, 32'd0, 32'd12, 1'b1, 1, d2);
        chk("b2b done gap", d2 - d1, 2);

        // annul mid-divide, with a competing start in the annul cycle
        @(posedge clk);
        #1;
        start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("annul busy", busy, 1'b0);
        count_done(40, dn);
        chk("annul no done", dn, 0);
        chk("annul hi kept", hi, 32'd0);
        chk("annul lo kept", lo, 32'd12);

        // annul wins over start while idle
        @(posedge clk);
        #1;
        start = 1'b1; annul = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0; annul = 1'b0;
        @(negedge clk);
        chk("idle annul busy", busy, 1'b0);
        count_done(5, dn);
        chk("idle annul no done", dn, 0);

        // reset mid-divide
        @(posedge clk);
        #1;
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst done", done, 1'b0);
        chk("mid rst hi", hi, 32'd0);
        chk("mid rst lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        count_done(40, dn);
        chk("post rst no done", dn, 0);
        run_op("post rst multu 3*4", 2'd1, 32'd3, 32'd4, 2, 32'd0, 32'd12, 1'b0, 1, d1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
